// File: rtl/ecc_decode_arbiter.sv
// Round-robin front end that time-shares one (8,4) extended-Hamming decoder
// among NUM_REQ requesters and keeps saturating error statistics.
module ecc_decode_arbiter #(
  parameter int  NUM_REQ     = 4,
  parameter int  DEC_LATENCY = 1,
  parameter int  CNT_W       = 16,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             dec_data_in,
  input  logic [3:0]             dec_data_out,
  input  logic [1:0]             dec_num_of_errors,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [3:0]             rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [1:0]             rsp_errors,
  input  logic                   stat_clr,
  output logic [CNT_W-1:0]       corr_cnt,
  output logic [CNT_W-1:0]       uncorr_cnt,
  output logic                   busy
);

  localparam int LAT_W = $clog2(DEC_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q,      state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [LAT_W-1:0]  wait_cnt_q,   wait_cnt_d;
  logic [7:0]        hold_q,       hold_d;
  logic              rsp_valid_q,  rsp_valid_d;
  logic [3:0]        rsp_data_q,   rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q,     rsp_id_d;
  logic [1:0]        rsp_errors_q, rsp_errors_d;
  logic [CNT_W-1:0]  corr_q,       corr_d;
  logic [CNT_W-1:0]  uncorr_q,     uncorr_d;
  logic              busy_q,       busy_d;

  logic              grant_found_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic [ID_W-1:0]   cand_idx_s;
  int                cand_s;
  logic [7:0]        grant_data_s;
  logic              capture_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Round-robin search beginning just after the previous winner.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = 0;
    cand_idx_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s     = (int'(last_grant_q) + k) % NUM_REQ;
      cand_idx_s = ID_W'(cand_s);
      if (!grant_found_s && req_valid[cand_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Codeword of the current winner.
  always_comb begin
    grant_data_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == ID_W'(i)) begin
        grant_data_s = req_data[8*i +: 8];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Accept strobe is only offered while idle.
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && grant_found_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Sequencer: accept, wait out the decoder latency, hold the response.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    hold_d       = hold_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_errors_d = rsp_errors_q;
    busy_d       = busy_q;
    capture_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          state_d      = S_WAIT;
          last_grant_d = grant_idx_s;
          wait_cnt_d   = LAT_W'(DEC_LATENCY);
          hold_d       = grant_data_s;
          busy_d       = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d      = S_RESP;
          capture_s    = 1'b1;
          hold_d       = 8'h00;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = dec_data_out;
          rsp_errors_d = dec_num_of_errors;
          rsp_id_d     = last_grant_q;
        end else begin
          wait_cnt_d = wait_cnt_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        hold_d      = 8'h00;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Statistics: a clear overrides a same-cycle increment; class 3 counts as uncorrectable.
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (stat_clr) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (capture_s) begin
      case (dec_num_of_errors)
        2'd0:    corr_d   = corr_q;
        2'd1:    corr_d   = sat_inc(corr_q);
        default: uncorr_d = sat_inc(uncorr_q);
      endcase
    end else begin
      corr_d = corr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      wait_cnt_q   <= '0;
      hold_q       <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 4'h0;
      rsp_id_q     <= '0;
      rsp_errors_q <= 2'd0;
      corr_q       <= '0;
      uncorr_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      hold_q       <= hold_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_errors_q <= rsp_errors_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      busy_q       <= busy_d;
    end
  end

  assign dec_data_in = hold_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_errors  = rsp_errors_q;
  assign corr_cnt    = corr_q;
  assign uncorr_cnt  = uncorr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ecc_decode_arbiter.sv
// Directed bench for ecc_decode_arbiter: a latency-1 instance with 4-bit
// counters driven by a stub decoder, plus a latency-3 instance for reset.
module tb_ecc_decode_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  dec_data_in;
  logic [3:0]  dec_data_out;
  logic [1:0]  dec_num_of_errors;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_errors;
  logic        stat_clr;
  logic [3:0]  corr_cnt;
  logic [3:0]  uncorr_cnt;
  logic        busy;

  logic [3:0]  req_valid3;
  logic [31:0] req_data3;
  logic [3:0]  req_ready3;
  logic [7:0]  dec_data_in3;
  logic [3:0]  dec_data_out3;
  logic [1:0]  dec_err3;
  logic        rsp_valid3;
  logic        rsp_ready3;
  logic [3:0]  rsp_data3;
  logic [1:0]  rsp_id3;
  logic [1:0]  rsp_errors3;
  logic        stat_clr3;
  logic [15:0] corr3;
  logic [15:0] uncorr3;
  logic        busy3;

  int checks = 0;
  int errors = 0;

  ecc_decode_arbiter #(.NUM_REQ(4), .DEC_LATENCY(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dec_data_in(dec_data_in), .dec_data_out(dec_data_out),
    .dec_num_of_errors(dec_num_of_errors), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_errors(rsp_errors), .stat_clr(stat_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .busy(busy)
  );

  ecc_decode_arbiter #(.NUM_REQ(4), .DEC_LATENCY(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_data(req_data3),
    .req_ready(req_ready3), .dec_data_in(dec_data_in3), .dec_data_out(dec_data_out3),
    .dec_num_of_errors(dec_err3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .rsp_id(rsp_id3), .rsp_errors(rsp_errors3), .stat_clr(stat_clr3),
    .corr_cnt(corr3), .uncorr_cnt(uncorr3), .busy(busy3)
  );

  always #5 clk = ~clk;

  // Stub decoder with one register stage: nibble = cw[7:4], class = cw[1:0].
  always @(posedge clk) begin
    dec_data_out      <= dec_data_in[7:4];
    dec_num_of_errors <= dec_data_in[1:0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = 4'b0000; req_data = 32'h0; rsp_ready = 1'b0; stat_clr = 1'b0;
    req_valid3 = 4'b0000; req_data3 = 32'h0; rsp_ready3 = 1'b0; stat_clr3 = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic send(input int id, input logic [7:0] cw);
    req_data = 32'h0;
    req_data[8*id +: 8] = cw;
    req_valid = 4'b0000;
    req_valid[id] = 1'b1;
    step();
    req_valid = 4'b0000;
    for (int i = 0; i < 10 && !rsp_valid; i++) step();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL send_timeout id %0d got rsp_valid %b exp 1", id, rsp_valid);
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 4'b0000; req_data = 32'h0; rsp_ready = 1'b0; stat_clr = 1'b0;
    req_valid3 = 4'b0000; req_data3 = 32'h0; rsp_ready3 = 1'b0; stat_clr3 = 1'b0;
    dec_data_out3 = 4'h9; dec_err3 = 2'd1;
    step(); step();
    checks++;
    if ({req_ready, rsp_valid, busy, dec_data_in} !== 14'h0) begin
      errors++; $display("FAIL reset_ctrl got %h exp 0", {req_ready, rsp_valid, busy, dec_data_in});
    end
    checks++;
    if ({rsp_data, rsp_id, rsp_errors} !== 8'h00) begin
      errors++; $display("FAIL reset_rsp got %h exp 0", {rsp_data, rsp_id, rsp_errors});
    end
    checks++;
    if ({corr_cnt, uncorr_cnt} !== 8'h00) begin
      errors++; $display("FAIL reset_cnt got %h exp 0", {corr_cnt, uncorr_cnt});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    req_data = 32'h0; req_data[23:16] = 8'h3C; req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got %b exp 0100", req_ready);
    end
    step();
    req_valid = 4'b0000;
    checks++;
    if ({req_ready, busy, dec_data_in} !== {4'b0000, 1'b1, 8'h3C}) begin
      errors++; $display("FAIL single_wait got %h exp %h", {req_ready, busy, dec_data_in}, {4'b0000, 1'b1, 8'h3C});
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_early got %b exp 0", rsp_valid);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_errors} !== {1'b1, 2'd2, 4'h3, 2'd0}) begin
      errors++; $display("FAIL single_rsp got %h exp %h", {rsp_valid, rsp_id, rsp_data, rsp_errors}, {1'b1, 2'd2, 4'h3, 2'd0});
    end
    checks++;
    if ({corr_cnt, uncorr_cnt, dec_data_in} !== 16'h0000) begin
      errors++; $display("FAIL single_cnt got %h exp 0", {corr_cnt, uncorr_cnt, dec_data_in});
    end
    ack();
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL single_done got %b exp 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (g % 4))) begin
        errors++; $display("FAIL rr_grant %0d got %b exp %b", g, req_ready, 4'(1 << (g % 4)));
      end
      step(); step(); step();
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(g % 4), 4'(g % 4 + 1)}) begin
        errors++; $display("FAIL rr_rsp %0d got %h exp %h", g, {rsp_valid, rsp_id, rsp_data}, {1'b1, 2'(g % 4), 4'(g % 4 + 1)});
      end
      step();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    req_data = 32'h0; req_data[15:8] = 8'h51; req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_grant got %b exp 0010", req_ready);
    end
    step(); step(); step();
    checks++;
    if (corr_cnt !== 4'd1) begin
      errors++; $display("FAIL bp_corr got %0d exp 1", corr_cnt);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({rsp_valid, rsp_data, rsp_id, rsp_errors, req_ready} !== {1'b1, 4'h5, 2'd1, 2'd1, 4'b0000}) begin
        errors++; $display("FAIL bp_hold %0d got %h exp %h", c, {rsp_valid, rsp_data, rsp_id, rsp_errors, req_ready}, {1'b1, 4'h5, 2'd1, 2'd1, 4'b0000});
      end
      step();
    end
    ack();
    checks++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
      errors++; $display("FAIL bp_regrant got %b exp 00010", {rsp_valid, req_ready});
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(0, 8'h11);
      ack();
      if (i == 13) begin
        checks++;
        if (corr_cnt !== 4'd14) begin
          errors++; $display("FAIL cnt_mid got %0d exp 14", corr_cnt);
        end
      end
    end
    checks++;
    if ({corr_cnt, uncorr_cnt} !== {4'd15, 4'd0}) begin
      errors++; $display("FAIL cnt_sat got %h exp f0", {corr_cnt, uncorr_cnt});
    end
    send(1, 8'h22); ack();
    send(1, 8'h22); ack();
    checks++;
    if ({corr_cnt, uncorr_cnt} !== {4'd15, 4'd2}) begin
      errors++; $display("FAIL cnt_uncorr got %h exp f2", {corr_cnt, uncorr_cnt});
    end
    req_data = 32'h0; req_data[23:16] = 8'h11; req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    checks++;
    if ({rsp_valid, corr_cnt, uncorr_cnt} !== {1'b1, 4'd0, 4'd0}) begin
      errors++; $display("FAIL cnt_clr got %h exp 100", {rsp_valid, corr_cnt, uncorr_cnt});
    end
    ack();
  endtask

  task automatic test_reserved();
    send(3, 8'h73);
    checks++;
    if ({rsp_errors, rsp_data, rsp_id} !== {2'd3, 4'h7, 2'd3}) begin
      errors++; $display("FAIL rsv_rsp got %h exp %h", {rsp_errors, rsp_data, rsp_id}, {2'd3, 4'h7, 2'd3});
    end
    checks++;
    if ({corr_cnt, uncorr_cnt} !== {4'd0, 4'd1}) begin
      errors++; $display("FAIL rsv_cnt got %h exp 01", {corr_cnt, uncorr_cnt});
    end
    ack();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_data3 = 32'h0000_00A5; req_valid3 = 4'b0001;
    #1;
    checks++;
    if (req_ready3 !== 4'b0001) begin
      errors++; $display("FAIL rmid_grant got %b exp 0001", req_ready3);
    end
    step();
    req_valid3 = 4'b0000;
    checks++;
    if ({busy3, dec_data_in3} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL rmid_wait got %h exp 1a5", {busy3, dec_data_in3});
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({busy3, rsp_valid3, dec_data_in3} !== 10'h000) begin
      errors++; $display("FAIL rmid_async got %h exp 0", {busy3, rsp_valid3, dec_data_in3});
    end
    step(); step();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if ({rsp_valid3, busy3} !== 2'b00) begin
        errors++; $display("FAIL rmid_norsp %0d got %b exp 00", c, {rsp_valid3, busy3});
      end
    end
    checks++;
    if ({rsp_data3, rsp_id3, rsp_errors3, corr3, uncorr3} !== 40'h0) begin
      errors++; $display("FAIL rmid_regs got %h exp 0", {rsp_data3, rsp_id3, rsp_errors3, corr3, uncorr3});
    end
    req_data3 = 32'hC300_005A; req_valid3 = 4'b1001;
    #1;
    checks++;
    if (req_ready3 !== 4'b0001) begin
      errors++; $display("FAIL rmid_prio got %b exp 0001", req_ready3);
    end
    step();
    req_valid3 = 4'b0000;
    checks++;
    if (dec_data_in3 !== 8'h5A) begin
      errors++; $display("FAIL rmid_data got %h exp 5a", dec_data_in3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_counters();
    test_reserved();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_decode_arbiter.md
# ecc_decode_arbiter

Shares one (8,4) extended-Hamming decoder among `NUM_REQ` requesters. The block arbitrates round-robin, sequences a single codeword through the decoder's fixed pipeline latency, and returns the decoded nibble, error class and requester ID on a valid/ready response port. It also keeps saturating statistics of corrected and uncorrectable codewords. It sits between the requesting datapaths and the decoder instance.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2. `ID_W = $clog2(NUM_REQ)` is derived, not overridable.
- `DEC_LATENCY`, 1: decoder input-to-output latency in clock edges, ≥1.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_data`  in  8*NUM_REQ  codewords; requester i at [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `dec_data_in`  out  8  codeword to the decoder.
- `dec_data_out`  in  4  decoded nibble from the decoder.
- `dec_num_of_errors`  in  2  decoder error class: 0 none, 1 corrected, 2 uncorrectable, 3 reserved.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  4  decoded nibble.
- `rsp_id`  out  ID_W  index of the requester served.
- `rsp_errors`  out  2  error class, as returned by the decoder.
- `stat_clr`  in  1  synchronous clear of the counters.
- `corr_cnt`  out  CNT_W  count of class-1 results, saturating.
- `uncorr_cnt`  out  CNT_W  count of class-2 and class-3 results, saturating.
- `busy`  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, pick the winner g. The search starts at `last_grant+1` and wraps modulo NUM_REQ.
  - `req_ready[g]` is driven combinationally high in that cycle only. All other `req_ready` bits are 0.
  - At the edge: latch `req_data[g]` into the hold register, set `last_grant<=g`, load the wait counter with DEC_LATENCY, and go to WAIT.
- **WAIT**
  - `dec_data_in` is driven from the hold register and stays stable for the whole state.
  - The counter decrements each cycle.
  - In the cycle where the counter reads 0:
    - capture `dec_data_out`/`dec_num_of_errors` into the `rsp_data`/`rsp_errors` registers,
    - set `rsp_id<=g`,
    - update the counters,
    - go to RESP.
- **RESP**
  - `rsp_valid=1`. All `rsp_*` outputs are held stable until `rsp_ready` is high.
  - On handshake, go to IDLE.
  - No request is accepted in WAIT or RESP; all `req_ready` bits are 0.
- `dec_data_in` is 8'h00 in IDLE and RESP.
- Counters:
  - +1 per capture, in the class given above.
  - Saturate at 2^CNT_W−1; no wrap.
  - `stat_clr` zeroes both counters. If a clear and an increment happen in the same cycle, the clear wins and the result is 0.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_errors`=0, `dec_data_in`=0, counters=0, `busy`=0, state=IDLE, `last_grant`=NUM_REQ−1 (so requester 0 has first priority).
- Reset asserted mid-WAIT or mid-RESP: the in-flight codeword and response are discarded; `rsp_valid` drops immediately (asynchronous reset).
- Requesters may drop `req_valid` at any time without a handshake. A request that drops before it is granted is simply not served.

## Timing
- Accept at cycle T (IDLE). WAIT spans T+1 … T+1+DEC_LATENCY. `rsp_valid` rises at T+DEC_LATENCY+2.
- With DEC_LATENCY=1: accept at T, `rsp_valid` at T+3.
- A response handshake at cycle R returns to IDLE at R+1. The next accept can happen at R+1.
- Minimum period per codeword: DEC_LATENCY+3 cycles.
- `busy` is registered with the state: high from T+1 until the cycle after the handshake.
- Counters change at the capture edge and are visible at T+DEC_LATENCY+2, together with `rsp_valid`.

## Test plan
- **Single request, clean codeword.** Requester 2 sends 8'h3C; the decoder model returns 4'h3 with class 0.
  - Expected: `req_ready`=4'b0100 at T.
  - At T+3: `rsp_valid`=1, `rsp_id`=2, `rsp_data`=4'h3, `rsp_errors`=0; counters unchanged.
- **Round-robin fairness.** All four `req_valid` held high, `rsp_ready` held high.
  - Expected grant order 0,1,2,3,0,1; one grant every 4 cycles.
- **Backpressure.** `rsp_ready` held low for 5 cycles with `req_valid[1]` high.
  - Expected: `rsp_*` stable for all 5 cycles; `req_ready`=0 throughout.
  - Requester 1 is granted in the cycle after the handshake.
- **Counter saturation and clear.** CNT_W=4, 17 class-1 results, then 2 class-2 results.
  - Expected: `corr_cnt`=15, `uncorr_cnt`=2.
  - `stat_clr` pulsed in the same cycle as a capture: both counters read 0 afterwards.
- **Reset mid-operation.** `rst` pulled low during WAIT with DEC_LATENCY=3.
  - Expected: `busy`, `rsp_valid` and `dec_data_in` go to 0 immediately; no response is ever produced.
  - After release, requester 0 wins against requester 3 when both are requesting.
- **Reserved class.** The decoder model returns class 3.
  - Expected: `rsp_errors`=3 and `uncorr_cnt` increments by 1.
